// File: rtl/line_buffer_3x3_pkg.sv
// Shared widths and FSM state type for the 3x3 line buffer.
package line_buffer_3x3_pkg;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned WIN_W = 9 * PIX_W;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StStream,
        StDone
    } lb_state_e;
endpackage

// File: rtl/line_mem.sv
// Single-port line RAM: combinational read returns the old word while a write lands at the edge.
module line_mem
    import line_buffer_3x3_pkg::*;
#(
    parameter int unsigned DEPTH = 416,
    parameter int unsigned WIDTH = PIX_W,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end
endmodule

// File: rtl/line_buffer_3x3.sv
// Raster-order 3x3 window generator built from two line memories and a 3x3 shift register.
// Define LINE_BUFFER_OUT_REG_EN to add an output register stage (window latency 2).
module line_buffer_3x3
    import line_buffer_3x3_pkg::*;
#(
    parameter int unsigned IMG_W = 416,
    parameter int unsigned IMG_H = 416
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic             pix_ready,
    output logic [WIN_W-1:0] win_out,
    output logic             win_valid,
    input  logic             win_ready,
    output logic             frame_done
);
    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    lb_state_e        state_q, state_d;
    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    logic [WIN_W-1:0] sr_q;
    logic             win_v_q;
    logic             stall;
    logic             accept;
    logic             in_frame;
    logic             take;
    logic             produce;
    logic [CW-1:0]    wr_addr;
    logic [PIX_W-1:0] lm1_rd;
    logic [PIX_W-1:0] lm2_rd;

    assign pix_ready  = !stall;
    assign accept     = pix_valid && pix_ready;
    assign in_frame   = (state_q == StFill) || (state_q == StStream);
    // sof always restarts at (0,0), so that pixel is stored regardless of state
    assign take       = accept && (sof || in_frame);
    assign wr_addr    = sof ? '0 : col_q;
    assign produce    = accept && !sof && in_frame && (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign frame_done = (state_q == StDone);

    // lm1 holds row r-1, lm2 holds row r-2; lm1's old word cascades into lm2
    line_mem #(
        .DEPTH(IMG_W),
        .WIDTH(PIX_W)
    ) u_lm1 (
        .clk  (clk),
        .we   (take),
        .addr (wr_addr),
        .wdata(pix_in),
        .rdata(lm1_rd)
    );

    line_mem #(
        .DEPTH(IMG_W),
        .WIDTH(PIX_W)
    ) u_lm2 (
        .clk  (clk),
        .we   (take),
        .addr (wr_addr),
        .wdata(lm1_rd),
        .rdata(lm2_rd)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        if (accept && sof) begin
            state_d = StFill;
            col_d   = CW'(1);
            row_d   = '0;
        end else begin
            unique case (state_q)
                StFill, StStream: begin
                    if (accept) begin
                        if (col_q == CW'(IMG_W - 1)) begin
                            col_d = '0;
                            if (row_q == RW'(IMG_H - 1)) begin
                                row_d   = '0;
                                state_d = StDone;
                            end else begin
                                row_d   = row_q + 1'b1;
                                state_d = (row_q >= RW'(1)) ? StStream : StFill;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            col_q   <= '0;
            row_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            if (take) begin
                sr_q <= {sr_q[63:48], lm2_rd, sr_q[39:24], lm1_rd, sr_q[15:0], pix_in};
            end
        end
    end

`ifdef LINE_BUFFER_OUT_REG_EN
    logic [WIN_W-1:0] out_q;
    logic             out_v_q;

    assign stall     = out_v_q && !win_ready;
    assign win_out   = out_q;
    assign win_valid = out_v_q;

    // Both stages advance together; a stalled final stage freezes the whole pipe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q   <= '0;
            out_v_q <= 1'b0;
            win_v_q <= 1'b0;
        end else if (!stall) begin
            out_q   <= sr_q;
            out_v_q <= win_v_q;
            win_v_q <= produce;
        end
    end
`else
    assign stall     = win_v_q && !win_ready;
    assign win_out   = sr_q;
    assign win_valid = win_v_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_v_q <= 1'b0;
        end else if (accept) begin
            win_v_q <= produce;
        end else if (win_ready) begin
            win_v_q <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_line_buffer_3x3.sv
// Scoreboard bench: a 4x4 and a 3x3 instance driven with directed and random frames.
module tb_line_buffer_3x3;
`ifdef LINE_BUFFER_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pix_in     [2];
    logic        pix_valid  [2];
    logic        sof        [2];
    logic        pix_ready  [2];
    logic [71:0] win_out    [2];
    logic        win_valid  [2];
    logic        win_ready  [2];
    logic        frame_done [2];

    int          errors = 0;
    int          checks = 0;
    logic [71:0] exp_q [2][$];
    logic [7:0]  fr [2][64];
    int          fd_seen [2];
    int          fd_exp [2];
    bit          mon_en = 0;
    bit          rand_rdy [2];
    bit          prev_stall [2];
    logic [71:0] prev_win [2];

    always #5 clk = ~clk;

    line_buffer_3x3 #(.IMG_W(4), .IMG_H(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in[0]), .pix_valid(pix_valid[0]), .sof(sof[0]),
        .pix_ready(pix_ready[0]), .win_out(win_out[0]), .win_valid(win_valid[0]),
        .win_ready(win_ready[0]), .frame_done(frame_done[0])
    );

    line_buffer_3x3 #(.IMG_W(3), .IMG_H(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in[1]), .pix_valid(pix_valid[1]), .sof(sof[1]),
        .pix_ready(pix_ready[1]), .win_out(win_out[1]), .win_valid(win_valid[1]),
        .win_ready(win_ready[1]), .frame_done(frame_done[1])
    );

    function automatic int sz(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    // Reference window: rows r-2..r, cols c-2..c of the stored frame, row-major, oldest first
    function automatic logic [71:0] win_of(input int d, input int r, input int c);
        logic [71:0] w;
        int          n;
        w = '0;
        n = sz(d);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w = {w[63:0], fr[d][(r - 2 + i) * n + c - 2 + j]};
        return w;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int d, input logic [7:0] p, input logic s);
        bit acc;
        acc          = 0;
        pix_in[d]    = p;
        sof[d]       = s;
        pix_valid[d] = 1'b1;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = pix_ready[d];
            @(posedge clk);
            #1;
        end
        pix_valid[d] = 1'b0;
        sof[d]       = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout dut%0d: pix_ready got 0, required 1", d);
        end
    endtask

    task automatic send_px(input int d, input int k);
        int n;
        n = sz(d);
        if ((k / n) >= 2 && (k % n) >= 2) exp_q[d].push_back(win_of(d, k / n, k % n));
        send(d, fr[d][k], k == 0);
        if (k == n * n - 1) fd_exp[d]++;
    endtask

    // Monitor: consumes windows against the scoreboard and checks hold/ready behaviour
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                if (prev_stall[d]) begin
                    chk($sformatf("hold_valid%0d", d), win_valid[d], 1);
                    chk($sformatf("hold_win%0d", d), win_out[d], prev_win[d]);
                end
                chk($sformatf("pix_ready%0d", d), pix_ready[d], !(win_valid[d] && !win_ready[d]));
                if (frame_done[d]) fd_seen[d]++;
                if (win_valid[d] && win_ready[d]) begin
                    if (exp_q[d].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_window dut%0d: got %h, required none", d,
                                 win_out[d]);
                    end else begin
                        chk($sformatf("window%0d", d), win_out[d], exp_q[d].pop_front());
                    end
                end
                prev_stall[d] = win_valid[d] && !win_ready[d];
                prev_win[d]   = win_out[d];
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++)
            if (rand_rdy[d]) win_ready[d] = ($urandom_range(0, 2) != 0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            pix_in[d]    = '0;
            pix_valid[d] = 1'b0;
            sof[d]       = 1'b0;
            win_ready[d] = 1'b1;
            fd_seen[d]   = 0;
            fd_exp[d]    = 0;
            rand_rdy[d]  = 0;
            prev_stall[d] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_win_valid", win_valid[d], 0);
            chk("reset_win_out", win_out[d], 0);
            chk("reset_frame_done", frame_done[d], 0);
            chk("reset_pix_ready", pix_ready[d], 1);
        end
        rst_n  = 1'b1;
        mon_en = 1;

        // Basic 4x4 frame, pixel = r*4+c
        for (int k = 0; k < 16; k++) fr[0][k] = 8'(k);
        for (int k = 0; k < 16; k++) begin
            send_px(0, k);
            if (k == 10) chk("first_latency", win_valid[0], LAT == 1);
            if (k == 9 + LAT) begin
                chk("first_valid", win_valid[0], 1);
                chk("first_window", win_out[0], 72'h00010204050608090A);
            end
            if (k == 15) chk("frame_done_pulse", frame_done[0], 1);
        end
        idle(1);
        chk("frame_done_single", frame_done[0], 0);
        idle(2);

        // Stall at the first window for 5 cycles
        win_ready[0] = 1'b0;
        for (int k = 0; k < 10 + LAT; k++) send_px(0, k);
        for (int i = 0; i < 5; i++) begin
            chk("stall_pix_ready", pix_ready[0], 0);
            chk("stall_window", win_out[0], 72'h00010204050608090A);
            idle(1);
        end
        win_ready[0] = 1'b1;
        for (int k = 10 + LAT; k < 16; k++) send_px(0, k);
        idle(3);

        // Abandon a frame after pixel 7, then a fresh frame
        for (int k = 0; k < 8; k++) send_px(0, k);
        for (int k = 0; k < 16; k++) fr[0][k] = 8'(8'h80 + k * 3);
        for (int k = 0; k < 16; k++) send_px(0, k);
        idle(3);

        // Reset mid-frame drops pending windows; later non-sof pixels are ignored
        for (int k = 0; k < 16; k++) fr[0][k] = 8'($urandom);
        for (int k = 0; k < 11; k++) send_px(0, k);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        exp_q[0].delete();
        chk("midreset_win_valid", win_valid[0], 0);
        chk("midreset_win_out", win_out[0], 0);
        chk("midreset_pix_ready", pix_ready[0], 1);
        for (int i = 0; i < 20; i++) send(0, 8'($urandom), 1'b0);
        idle(3);
        chk("idle_no_window", win_valid[0], 0);

        // 3x3 image: exactly one window of all nine pixels
        for (int k = 0; k < 9; k++) fr[1][k] = 8'($urandom);
        for (int k = 0; k < 9; k++) send_px(1, k);
        idle(3);

        // Random frames, random backpressure, random aborts and gaps
        for (int d = 0; d < 2; d++) begin
            int n;
            int npix;
            n = sz(d);
            rand_rdy[d] = 1;
            for (int f = 0; f < 12; f++) begin
                for (int k = 0; k < n * n; k++) fr[d][k] = 8'($urandom);
                npix = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n * n - 1) : n * n;
                for (int k = 0; k < npix; k++) begin
                    send_px(d, k);
                    idle($urandom_range(0, 1));
                end
                if (npix == n * n && $urandom_range(0, 1) == 1) send(d, 8'($urandom), 1'b0);
            end
            rand_rdy[d] = 0;
            idle(1);
            win_ready[d] = 1'b1;
        end

        for (int i = 0; i < 200 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); i++) idle(1);
        idle(2);
        chk("drain_dut0", exp_q[0].size(), 0);
        chk("drain_dut1", exp_q[1].size(), 0);
        chk("frame_done_count0", fd_seen[0], fd_exp[0]);
        chk("frame_done_count1", fd_seen[1], fd_exp[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/line_buffer_3x3.md
LINE_BUFFER_3X3 -- requirements
Module: line_buffer_3x3

Interface
REQ-001 SHALL have parameter IMG_W, default 416, meaning pixels per row (minimum 3).
REQ-002 SHALL have parameter IMG_H, default 416, meaning rows per frame (minimum 3).
REQ-003 SHALL have one clock; reset is synchronous and active-low: ports clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 pix_in  input  8  raster-order pixel.
REQ-007 pix_valid  input  1  pix_in is valid this cycle.
REQ-008 sof  input  1  start of frame; qualified by pix_valid, marks the pixel at (0,0).
REQ-009 pix_ready  output  1  block accepts pix_in this cycle.
REQ-010 win_out  output  72  3x3 window, row-major; [71:64] is top-left, [7:0] is bottom-right (newest pixel).
REQ-011 win_valid  output  1  win_out holds a valid window.
REQ-012 win_ready  input  1  downstream conv stage consumes win_out.
REQ-013 frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-014 Pixel accepted when pix_valid && pix_ready; pix_ready = !(win_valid && !win_ready).
REQ-015 Two IMG_W x 8 line memories plus a 3x3 shift register SHALL hold rows r-2, r-1 and r.
REQ-016 Column counter SHALL wrap IMG_W-1 -> 0 and increment the row counter; the row counter SHALL wrap IMG_H-1 -> 0.
REQ-017 FSM states: IDLE (wait for sof&&pix_valid), FILL (rows 0-1), STREAM (rows 2..IMG_H-1), DONE (one cycle, frame_done=1, then IDLE).
REQ-018 Pixels accepted in IDLE without sof SHALL be discarded; pix_ready SHALL be 1 in IDLE.
REQ-019 Accepting pixel (r,c) with r>=2 and c>=2 SHALL set win_valid next cycle, with win_out = pixels rows r-2..r, cols c-2..c.
REQ-020 Windows SHALL never span a row wrap; exactly (IMG_W-2)*(IMG_H-2) windows per frame.
REQ-021 While stalled, win_out, win_valid, counters and line memories SHALL hold.
REQ-022 Simultaneous win_ready consumption and new pixel acceptance SHALL replace win_out with no bubble.
REQ-023 sof with pix_valid in any state SHALL restart at (0,0) and enter FILL; any partial frame is abandoned without a frame_done pulse.
REQ-024 win_valid SHALL clear when consumed and no new window is produced the same cycle.

Reset
REQ-025 With rst_n=0 at a clk edge: state=IDLE, counters=0, win_valid=0, win_out=0, frame_done=0, pix_ready=1.
REQ-026 Line-memory contents SHALL need no reset; windows are only produced after refill.
REQ-027 Reset mid-frame SHALL drop all pending windows.

Configuration
REQ-028 Macro LINE_BUFFER_OUT_REG_EN: when defined, an extra output register SHALL be added; window latency becomes 2 cycles; the stall rule in REQ-014 applies to the final stage, and both stages hold on stall.
REQ-029 Without LINE_BUFFER_OUT_REG_EN, the window latency SHALL be 1 cycle, as in REQ-019.

Structure
REQ-030 A shared package SHALL hold PIX_W=8, WIN_W=72, and the FSM state enum.
REQ-031 One sub-module, line_mem (single-port IMG_W x PIX_W read-before-write RAM), SHALL be instantiated twice.

Verification
REQ-032 IMG_W=4, IMG_H=4, pixel=r*4+c, win_ready=1 -> first win_out=0x00010204050608090A one cycle after pixel 10; exactly 4 windows; frame_done pulses once after pixel 15.
REQ-033 Same frame, win_ready=0 for 5 cycles at the first window -> pix_ready=0, win_out held; all 4 windows are still delivered in order.
REQ-034 sof reasserted after pixel 7 -> no window and no frame_done from the abandoned frame; the new frame yields 4 correct windows.
REQ-035 rst_n=0 for one cycle mid-frame -> next cycle win_valid=0 and state IDLE; pixels without sof are ignored.
REQ-036 IMG_W=3, IMG_H=3 -> exactly one window, equal to the 9 input pixels in order.
REQ-037 LINE_BUFFER_OUT_REG_EN defined -> same windows as REQ-032, each one cycle later.
